// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: phase-controlled divided enables, stall gating, coincidence strobe, pause/drain handshake.
// Optional per-channel cycle counters are built when CLK_EN_GEN_CYCLE_COUNT_EN is defined; otherwise cycle_cnt reads zero.
module clk_en_gen #(
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned DIV   [NUM_CH] = '{12, 4, 2},
    parameter int unsigned PHASE [NUM_CH] = '{0, 0, 0},
    parameter int unsigned CNT_W          = 64
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             stall,
    input  logic                             pause_req,
    output logic                             pause_ack,
    output logic [NUM_CH-1:0]                clk_en,
    output logic                             all_en,
    output logic [NUM_CH-1:0][CNT_W-1:0]     cycle_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t            state;
    logic              frozen;
    wire  [NUM_CH-1:0] raw;

    assign frozen = stall | (state == PAUSED);
    assign clk_en = raw & {NUM_CH{~frozen}};
    assign all_en = &clk_en;

    // Per-channel divide counter, sized to its own ratio; DIV of 1 keeps a single constant-zero bit.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int unsigned DW = (DIV[i] > 1) ? $clog2(DIV[i]) : 1;

        logic [DW-1:0] div_cnt;

        assign raw[i] = (div_cnt == DW'(DIV[i] - 1));

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                div_cnt <= DW'(PHASE[i]);
            end else if (!frozen) begin
                div_cnt <= raw[i] ? '0 : div_cnt + DW'(1);
            end
        end
    end

`ifdef CLK_EN_GEN_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q[i] <= '0;
            end else if (clk_en[i]) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cycle_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cycle_cnt[i] = cnt_q[i];
        end
    end
`else
    assign cycle_cnt = '0;
`endif

    // Pause handshake: the coincidence edge that enters PAUSED is itself issued, so ack rises one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            pause_ack <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (pause_req && all_en) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end else if (pause_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pause_req) begin
                        state <= RUN;
                    end else if (all_en) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause_req) begin
                        state     <= RUN;
                        pause_ack <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    pause_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule
